cpu_phase_sequencer: RTL and testbench

Parametrised timing generator for the multi-cycle CPU top level. It replaces the hard-wired 3-bit state counter that derives cpu_clk, the PC enable and the register-file write enable. It adds three things: a configurable phase count and prescaler, selectable run/step/halt modes with a debounced step button, and a retired-instruction counter for the board display.

---
 rtl/cpu_phase_sequencer.sv | 91 +++++++++
 tb/tb_cpu_phase_sequencer.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/cpu_phase_sequencer.sv
// cpu_phase_sequencer: phase/timing generator for the multi-cycle CPU with run/step/halt control
module cpu_phase_sequencer #(
   parameter int PHASE_W         = 3,
   parameter int PREDIV          = 1,
   parameter int CLK_BIT         = 1,
   parameter int PC_EN_PHASES    = 2,
   parameter int REG_WE_PHASE    = 6,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int COUNT_W         = 16
) (
   input  logic               clk,
   input  logic               rst_a,
   input  logic [1:0]         mode,
   input  logic               step_btn,
   output logic [PHASE_W-1:0] phase,
   output logic               cpu_clk,
   output logic               pc_en,
   output logic               reg_we,
   output logic               halted,
   output logic [COUNT_W-1:0] instr_count,
   output logic               step_seen
);
   localparam int PHASES = 2 ** PHASE_W;
   localparam int PRE_W  = PREDIV > 1 ? $clog2(PREDIV) : 1;
   localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES);
   typedef enum logic {IDLE, RUN} state_t;
   state_t             state, state_n;
   logic [PRE_W-1:0]   pre, pre_n;
   logic [PHASE_W-1:0] phase_n;
   logic [COUNT_W-1:0] count_n;
   logic               tick, wrap, start;
   logic               sync1, sync2, stable, deb_done;
   logic [DEB_W-1:0]   deb_cnt;
   assign deb_done = (sync2 != stable) && (deb_cnt == DEB_W'(DEBOUNCE_CYCLES - 1));
   // synchronise the button and accept a level only after it has held for DEBOUNCE_CYCLES samples
   always_ff @(posedge clk or negedge rst_a) begin
      if (!rst_a) begin
         sync1     <= 1'b0;
         sync2     <= 1'b0;
         stable    <= 1'b0;
         deb_cnt   <= '0;
         step_seen <= 1'b0;
      end else begin
         sync1     <= step_btn;
         sync2     <= sync1;
         step_seen <= deb_done & sync2;
         stable    <= deb_done ? sync2 : stable;
         deb_cnt   <= (sync2 == stable || deb_done) ? '0 : deb_cnt + 1'b1;
      end
   end
   // next state: prescaled phase stepping, mode sampled only at the instruction boundary
   always_comb begin
      tick    = pre == PRE_W'(PREDIV - 1);
      wrap    = state == RUN && tick && phase == PHASE_W'(PHASES - 1);
      start   = mode == 2'b00 || (mode == 2'b01 && step_seen);
      state_n = state;
      pre_n   = '0;
      phase_n = '0;
      count_n = instr_count;
      if (state == IDLE) begin
         state_n = start ? RUN : IDLE;
      end else begin
         pre_n   = tick ? '0 : pre + 1'b1;
         phase_n = tick ? phase + 1'b1 : phase;
         count_n = wrap ? instr_count + 1'b1 : instr_count;
         state_n = wrap ? (mode == 2'b00 ? RUN : IDLE) : RUN;
      end
   end
   // state and outputs registered from next-state values so they are glitch-free and phase-aligned
   always_ff @(posedge clk or negedge rst_a) begin
      if (!rst_a) begin
         state       <= IDLE;
         pre         <= '0;
         phase       <= '0;
         instr_count <= '0;
         halted      <= 1'b1;
         cpu_clk     <= 1'b0;
         pc_en       <= 1'b0;
         reg_we      <= 1'b0;
      end else begin
         state       <= state_n;
         pre         <= pre_n;
         phase       <= phase_n;
         instr_count <= count_n;
         halted      <= state_n == IDLE;
         cpu_clk     <= state_n == RUN && phase_n[CLK_BIT];
         pc_en       <= state_n == RUN && {1'b0, phase_n} < (PHASE_W + 1)'(PC_EN_PHASES);
         reg_we      <= state_n == RUN && phase_n == PHASE_W'(REG_WE_PHASE);
      end
   end
endmodule

// File: tb/tb_cpu_phase_sequencer.sv
// tb_cpu_phase_sequencer: randomized run/step/halt checks against a pass-level reference model
module tb_cpu_phase_sequencer;
   localparam int PHASE_W = 3;
   localparam int PREDIV  = 3;
   localparam int DEB     = 16;
   localparam int CW      = 4;
   localparam int PASS    = (2 ** PHASE_W) * PREDIV;
   logic              clk = 1'b0;
   logic              rst_a = 1'b0;
   logic [1:0]        mode = 2'b00;
   logic              step_btn = 1'b0;
   logic [PHASE_W-1:0] phase;
   logic              cpu_clk, pc_en, reg_we, halted, step_seen;
   logic [CW-1:0]     instr_count;
   int                total = 0;
   int                bad = 0;
   bit                hist[$];
   bit                m_stable, m_seen, m_run, flip;
   int                m_t, m_cnt;

   cpu_phase_sequencer #(.PHASE_W(PHASE_W), .PREDIV(PREDIV), .CLK_BIT(1), .PC_EN_PHASES(2),
                         .REG_WE_PHASE(6), .DEBOUNCE_CYCLES(DEB), .COUNT_W(CW)) dut (
      .clk(clk), .rst_a(rst_a), .mode(mode), .step_btn(step_btn), .phase(phase),
      .cpu_clk(cpu_clk), .pc_en(pc_en), .reg_we(reg_we), .halted(halted),
      .instr_count(instr_count), .step_seen(step_seen)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   // reference: a press is accepted once the twice-delayed button has disagreed with the accepted
   // level for DEB consecutive samples; a pass is PASS clk cycles long, phase = elapsed / PREDIV
   always @(posedge clk or negedge rst_a) begin
      if (!rst_a) begin
         hist.delete();
         m_stable = 0;
         m_seen = 0;
         m_run = 0;
         m_t = 0;
         m_cnt = 0;
      end else begin
         hist.push_front(step_btn);
         if (hist.size() > DEB + 2) void'(hist.pop_back());
         flip = hist.size() == DEB + 2;
         for (int i = 2; i < DEB + 2; i++) if (hist[i] == m_stable) flip = 0;
         if (!m_run) begin
            m_run = mode == 2'b00 || (mode == 2'b01 && m_seen);
            m_t = 0;
         end else if (m_t == PASS - 1) begin
            m_t = 0;
            m_cnt = (m_cnt + 1) % (1 << CW);
            m_run = mode == 2'b00;
         end else begin
            m_t++;
         end
         m_seen = flip && !m_stable;
         if (flip) m_stable = !m_stable;
      end
   end

   always @(negedge clk) begin
      int ph;
      ph = m_run ? m_t / PREDIV : 0;
      chk("phase", phase, ph);
      chk("cpu_clk", cpu_clk, m_run && ((ph >> 1) & 1));
      chk("pc_en", pc_en, m_run && ph < 2);
      chk("reg_we", reg_we, m_run && ph == 6);
      chk("halted", halted, !m_run);
      chk("instr_count", instr_count, m_cnt);
      chk("step_seen", step_seen, m_seen);
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_phase(input int p);
      int n = 0;
      while (phase != p && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("reach_phase", phase, p);
   endtask

   task automatic press(input int bounce_len, input int bounce_per, input int hold);
      for (int i = 0; i < bounce_len; i++) begin
         if (i % bounce_per == 0) step_btn = ~step_btn;
         @(negedge clk);
      end
      step_btn = 1'b1;
      cycles(hold);
      step_btn = 1'b0;
   endtask

   initial begin
      cycles(3);
      chk("rst_halted", halted, 1);
      chk("rst_count", instr_count, 0);
      rst_a = 1'b1;
      cycles(1);
      chk("run_start", halted, 0);
      wait_phase(5);
      @(posedge clk);
      #2 rst_a = 1'b0;
      #1;
      chk("async_phase", phase, 0);
      chk("async_cpu_clk", cpu_clk, 0);
      chk("async_pc_en", pc_en, 0);
      chk("async_reg_we", reg_we, 0);
      chk("async_halted", halted, 1);
      chk("async_count", instr_count, 0);
      @(negedge clk);
      rst_a = 1'b1;
      cycles(PASS * 17 + 5);
      wait_phase(3);
      mode = 2'b10;
      cycles(PASS + 10);
      chk("halt_stop", halted, 1);
      mode = 2'b01;
      cycles(30);
      press(0, 1, 25);
      cycles(60);
      press(0, 1, 25);
      cycles(60);
      step_btn = 1'b0;
      press(60, 5, 30);
      cycles(50);
      press(0, 1, 25);
      press(0, 1, 25);
      cycles(60);
      for (int k = 0; k < 40; k++) begin
         int r = $urandom_range(0, 19);
         mode = r < 14 ? 2'b01 : r < 17 ? 2'b00 : 2'($urandom_range(2, 3));
         press($urandom_range(0, 1) ? $urandom_range(0, 40) : 0, $urandom_range(1, 6), $urandom_range(0, 40));
         cycles($urandom_range(0, 40));
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
